mult_seq_ctrl: RTL and testbench

- Shift-add sequencer for the 16x9 sequential multiplier.
- Owns the multiplicand, accumulator and multiplier-shift registers, and the iteration counter.
- Drives the external 16-bit adder (IN1/IN2 -> 17-bit SUM) once per cycle and assembles the 25-bit product.
- Uses a START/BUSY/DONE handshake toward the upstream requester.

---
 rtl/mult_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-add sequencer for a 16x9 unsigned sequential multiplier.
// Holds multiplicand M, accumulator A, multiplier/low-product shift register Q
// and the iteration counter. It drives an external adder once per cycle and
// assembles the 25-bit product after MPLIER_W iterations.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request pulse, sampled only in IDLE
//   mcand    in   multiplicand, captured when start is accepted
//   mplier   in   multiplier, captured when start is accepted
//   add_sum  in   17-bit sum returned combinationally by the external adder
//   add_in1  out  adder operand: accumulator A (combinational from registers)
//   add_in2  out  adder operand: M when Q[0]=1, else 0 (combinational from registers)
//   product  out  registered product, held until the next completion
//   busy     out  high while iterating (CALC)
//   done     out  one-cycle pulse when product becomes valid (FIN)
module mult_seq_ctrl #(
    parameter int unsigned MCAND_W  = 16,
    parameter int unsigned MPLIER_W = 9,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [MCAND_W-1:0]           mcand,
    input  logic [MPLIER_W-1:0]          mplier,
    input  logic [MCAND_W:0]             add_sum,
    output logic [MCAND_W-1:0]           add_in1,
    output logic [MCAND_W-1:0]           add_in2,
    output logic [MCAND_W+MPLIER_W-1:0]  product,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned      PROD_W   = MCAND_W + MPLIER_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MPLIER_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [MCAND_W-1:0]    a_q, a_d;
    logic [MPLIER_W-1:0]   q_q, q_d;
    logic [MCAND_W-1:0]    m_q, m_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PROD_W-1:0]     product_d;
    logic                  busy_d;
    logic                  done_d;

    // Adder operands come straight from the registers; all are reset so never X.
    assign add_in1 = a_q;
    assign add_in2 = q_q[0] ? m_q : '0;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            product <= product_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = mcand;
                    q_d     = mplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Shift the full 17-bit sum right through {A,Q}; carry lands in A's MSB.
                a_d   = add_sum[MCAND_W:1];
                q_d   = {add_sum[0], q_q[MPLIER_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Capture the result of the final step, not the pre-step registers.
                    product_d = {a_d, q_d};
                    state_d   = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered flags track the state being entered so they align with it.
        busy_d = (state_d == CALC);
        done_d = (state_d == FIN);
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: expected products are queued at request
// time, and a negedge monitor pops and compares on every done pulse while also
// checking busy/done exclusivity, done width, product stability and X-freedom.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mcand = '0;
    logic [8:0]  mplier = '0;
    logic [16:0] add_sum;
    logic [15:0] add_in1;
    logic [15:0] add_in2;
    logic [24:0] product;
    logic        busy;
    logic        done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [24:0] exp_q[$];
    logic [24:0] exp_v;
    logic        mon_en = 1'b0;
    logic        rst_at_edge = 1'b1;
    logic        prev_done = 1'b0;
    logic [24:0] prev_product = '0;

    always #5 clk = ~clk;

    // External 16-bit adder with carry out.
    assign add_sum = {1'b0, add_in1} + {1'b0, add_in2};

    mult_seq_ctrl #(
        .MCAND_W (16),
        .MPLIER_W(9),
        .CNT_W   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .add_sum(add_sum),
        .add_in1(add_in1),
        .add_in2(add_in2),
        .product(product),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_at_edge <= rst;

    // Monitor: runs on negedge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("no_x", 32'($isunknown({add_in1, add_in2, busy, done, product})), 32'd0);
            check("busy_and_done", 32'(busy & done), 32'd0);
            check("done_width", 32'(prev_done & done), 32'd0);
            if (!rst_at_edge && !done)
                check("product_stable", 32'(product), 32'(prev_product));
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: product %0d, required no done", product);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("product", 32'(product), 32'(exp_v));
                end
            end
        end
        prev_done    <= done;
        prev_product <= product;
    end

    // One operation; inj pulses a 7x7 start on that busy cycle, rst_at resets on that busy cycle.
    task automatic run_op(input logic [15:0] mc, input logic [8:0] mp, input logic [24:0] ex,
                          input int inj, input int rst_at);
        int  cyc;
        int  nb;
        bit  aborted;
        nb      = 0;
        aborted = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        if (rst_at == 0) exp_q.push_back(ex);
        for (cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_product", 32'(product), 32'd0);
                aborted = 1'b1;
                break;
            end
            if (done) break;
            if (busy) nb++;
            if (cyc == inj) begin
                start  = 1'b1;
                mcand  = 16'd7;
                mplier = 9'd7;
            end
            if (cyc == rst_at) rst = 1'b1;
        end
        if (!aborted) begin
            check("done_latency", 32'(cyc), 32'd10);
            check("busy_cycles", 32'(nb), 32'd9);
            @(negedge clk);
            check("done_low_after", 32'(done), 32'd0);
        end
    endtask

    // Start held high: two operations back to back, done pulses 11 cycles apart.
    task automatic run_b2b();
        int t1;
        int t2;
        t1 = 0;
        t2 = 0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = 16'd10;
        mplier = 9'd20;
        exp_q.push_back(25'd200);
        exp_q.push_back(25'd102400);
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                mcand  = 16'd400;
                mplier = 9'd256;
            end
            if (cyc == 12) start = 1'b0;
            if (cyc == 15) check("b2b_hold", 32'(product), 32'd200);
            if (done) begin
                if (t1 == 0) t1 = cyc;
                else         t2 = cyc;
            end
        end
        check("b2b_first_done", 32'(t1), 32'd10);
        check("b2b_spacing", 32'(t2 - t1), 32'd11);
    endtask

    initial begin
        logic [15:0] rmc;
        logic [8:0]  rmp;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        mon_en = 1'b1;

        run_op(16'd3,     9'd5,   25'd15,       0, 0);
        run_op(16'd65535, 9'd511, 25'd33488385, 0, 0);
        run_op(16'd0,     9'd511, 25'd0,        0, 0);
        run_op(16'd65535, 9'd0,   25'd0,        0, 0);
        run_op(16'd1000,  9'd300, 25'd300000,   4, 0);
        run_op(16'd1234,  9'd99,  25'd122166,   0, 5);
        run_op(16'd2,     9'd3,   25'd6,        0, 0);
        run_b2b();
        run_op(16'd1,     9'd1,   25'd1,        0, 0);
        run_op(16'd65535, 9'd1,   25'd65535,    0, 0);
        run_op(16'd1,     9'd511, 25'd511,      0, 0);
        run_op(16'd256,   9'd256, 25'd65536,    0, 0);
        run_op(16'd12345, 9'd123, 25'd1518435,  0, 0);

        for (int i = 0; i < 1000; i++) begin
            rmc = 16'($urandom);
            rmp = 9'($urandom);
            run_op(rmc, rmp, 25'(25'(rmc) * 25'(rmp)), 0, 0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
